// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the EX-stage divide sequencer.
//   - divider state encoding (2 bits)
//   - result-ready / start-stop strobe values
//   - DIV/DIVU function and aluop codes
//   - neg32 helper used for magnitude and sign correction
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [5:0] EXE_DIV     = 6'b011010;
  localparam logic [5:0] EXE_DIVU    = 6'b011011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [5:0] DIV_ITERATIONS = 6'd32;

  // Two's complement negation, modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration.
// Ports:
//   div_i      in  65  current dividend/partial-remainder register
//   divisor_i  in  32  divisor magnitude
//   div_o      out 65  register value after this iteration
module div_step (
  input  logic [64:0] div_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] div_o
);

  logic [32:0] trial_s;

  // Trial subtract; bit 32 set means the partial remainder is below the divisor.
  always_comb begin
    trial_s = {1'b0, div_i[63:32]} - {1'b0, divisor_i};
    if (trial_s[32]) begin
      div_o = {div_i[63:0], 1'b0};
    end else begin
      div_o = {trial_s[31:0], div_i[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer for the EX stage.
// 32-iteration restoring divide, one quotient bit per clock; 34-cycle latency,
// 2-cycle latency for divide by zero (result 0).
// Optional feature macro: DIV_SIGNED_EN (honour signed_div_i; otherwise all
// divides are unsigned and the negation logic is absent).
// Ports:
//   clk           in  1   system clock
//   rst           in  1   synchronous active-high reset
//   signed_div_i  in  1   1 = DIV (signed), 0 = DIVU
//   opdata1_i     in  32  dividend
//   opdata2_i     in  32  divisor
//   start_i       in  1   request, held until the result is consumed
//   annul_i       in  1   abort the in-flight divide
//   result_o      out 64  {remainder, quotient}, registered
//   ready_o       out 1   result valid, registered
//   stallreq_o    out 1   start_i & ~ready_o
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] div_q, div_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic        op1_neg_q, op1_neg_d;
  logic        op2_neg_q, op2_neg_d;

  logic [64:0] step_div;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [31:0] quotient_fix;
  logic [31:0] remainder_fix;

  div_step u_div_step (
    .div_i     (div_q),
    .divisor_i (divisor_q),
    .div_o     (step_div)
  );

`ifdef DIV_SIGNED_EN
  // Operand magnitudes and post-divide sign correction.
  always_comb begin
    op1_neg_d = signed_div_i & opdata1_i[31];
    op2_neg_d = signed_div_i & opdata2_i[31];
    op1_abs   = op1_neg_d ? neg32(opdata1_i) : opdata1_i;
    op2_abs   = op2_neg_d ? neg32(opdata2_i) : opdata2_i;
    // Quotient sign follows the operand sign difference; remainder follows the dividend.
    quotient_fix  = (op1_neg_q ^ op2_neg_q) ? neg32(div_q[31:0]) : div_q[31:0];
    remainder_fix = op1_neg_q ? neg32(div_q[64:33]) : div_q[64:33];
  end
`else
  // Sign handling disabled: every divide runs unsigned.
  wire unused_signed_div = signed_div_i ^ op1_neg_q ^ op2_neg_q;
  always_comb begin
    op1_neg_d     = 1'b0;
    op2_neg_d     = 1'b0;
    op1_abs       = opdata1_i;
    op2_abs       = opdata2_i;
    quotient_fix  = div_q[31:0];
    remainder_fix = div_q[64:33];
  end
`endif

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = 64'd0;
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = 6'd0;
            divisor_d = op2_abs;
            div_d     = {32'd0, op1_abs, 1'b0};
          end
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          // Result is published here so ready_o rises on the first DivEnd cycle.
          state_d  = DIV_END;
          div_d    = 65'd0;
          result_d = 64'd0;
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i || (start_i == DIV_STOP)) begin
          state_d  = DIV_FREE;
          cnt_d    = 6'd0;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = 64'd0;
        end else if (cnt_q != DIV_ITERATIONS) begin
          div_d = step_div;
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          cnt_d    = 6'd0;
          result_d = {remainder_fix, quotient_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = 64'd0;
        end else begin
          state_d = DIV_END;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        cnt_d    = 6'd0;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = 64'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= 6'd0;
      div_q     <= 65'd0;
      divisor_q <= 32'd0;
      result_q  <= 64'd0;
      ready_q   <= DIV_RESULT_NOT_READY;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      if (state_q == DIV_FREE) begin
        op1_neg_q <= op1_neg_d;
        op2_neg_q <= op2_neg_d;
      end else begin
        op1_neg_q <= op1_neg_q;
        op2_neg_q <= op2_neg_q;
      end
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int total_checks;
  int passed_checks;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge where start_i has just been raised (cycle 0).
  task automatic wait_result(input string name, input logic [63:0] exp, input int exp_lat);
    int lat;
    logic stall_ok;
    lat = 0;
    stall_ok = 1'b1;
    #1;
    if (stallreq_o !== 1'b1) stall_ok = 1'b0;
    while (ready_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ready_o !== 1'b1 && stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result_o, exp);
    check({name, " stall while busy"}, {63'd0, stall_ok}, 64'd1);
    check({name, " stall at ready"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  task automatic release_start(input string name);
    start_i = 1'b0;
    @(negedge clk);
    check({name, " ready clear"}, {63'd0, ready_o}, 64'd0);
    check({name, " result clear"}, result_o, 64'd0);
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;

    vecs[0]  = '{"u100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},               34};
    vecs[1]  = '{"uffff_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},         34};
    vecs[2]  = '{"u7_100",   1'b0, 32'd7,          32'd100,        {32'd7, 32'd0},                34};
    vecs[3]  = '{"uffff_ff", 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1},                34};
    vecs[4]  = '{"u1234",    1'b0, 32'h12345678,   32'h00001000,   {32'h00000678, 32'h00012345},  34};
    vecs[5]  = '{"u1m_3",    1'b0, 32'd1000000,    32'd3,          {32'd1, 32'h00051615},         34};
    vecs[6]  = '{"divzero",  1'b0, 32'd5,          32'd0,          64'd0,                         2};
`ifdef DIV_SIGNED_EN
    vecs[7]  = '{"s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},  34};
    vecs[8]  = '{"smin_-1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000},  34};
    vecs[9]  = '{"s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},         34};
    vecs[10] = '{"s-100_-7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E},  34};
`else
    vecs[7]  = '{"s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'd1, 32'h7FFFFFFC},         34};
    vecs[8]  = '{"smin_-1",  1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0},         34};
    vecs[9]  = '{"s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd7, 32'd0},                34};
    vecs[10] = '{"s-100_-7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFF9C, 32'd0},         34};
`endif
    vecs[11] = '{"sdivzero", 1'b1, 32'hFFFFFFF9,   32'd0,          64'd0,                         2};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", {63'd0, stallreq_o}, 64'd0);

    // Table of full divides
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_result(vecs[i].name, vecs[i].exp, vecs[i].lat);
      release_start(vecs[i].name);
    end

    // Hold start in DivEnd for 3 cycles
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    wait_result("hold", {32'd2, 32'd14}, 34);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold ready", {63'd0, ready_o}, 64'd1);
      check("hold result", result_o, {32'd2, 32'd14});
    end
    release_start("hold");

    // Annul pulsed in cycle 10, new DIVU starts in cycle 11
    @(negedge clk);
    launch(1'b0, 32'd1000, 32'd3);
    for (int k = 0; k < 10; k++) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul ready", {63'd0, ready_o}, 64'd0);
    launch(1'b0, 32'hFFFFFFFF, 32'd1);
    wait_result("after annul", {32'd0, 32'hFFFFFFFF}, 34);
    release_start("after annul");

    // Abort by dropping start_i mid-divide
    @(negedge clk);
    launch(1'b0, 32'd50, 32'd9);
    for (int k = 0; k < 5; k++) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("drop ready", {63'd0, ready_o}, 64'd0);
    check("drop stall", {63'd0, stallreq_o}, 64'd0);
    launch(1'b0, 32'd100, 32'd7);
    wait_result("after drop", {32'd2, 32'd14}, 34);
    release_start("after drop");

    // Simultaneous start and annul in DivFree is ignored
    @(negedge clk);
    annul_i = 1'b1;
    launch(1'b0, 32'd9, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("start+annul ready", {63'd0, ready_o}, 64'd0);
    annul_i = 1'b0;
    launch(1'b0, 32'd9, 32'd2);
    wait_result("after start+annul", {32'd1, 32'd4}, 34);
    release_start("after start+annul");

    // Reset in cycle 20 of a divide
    @(negedge clk);
    launch(1'b0, 32'd12345, 32'd11);
    for (int k = 0; k < 20; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset ready", {63'd0, ready_o}, 64'd0);
    check("midreset result", result_o, 64'd0);
    launch(1'b0, 32'd12345, 32'd11);
    wait_result("after reset", {32'd3, 32'd1122}, 34);
    release_start("after reset");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
